pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central sequencing controller for the 5-stage pipeline (F/D/X/M/W). Observes the instruction registers of D, X, M and W. Produces:
- stall, flush and bubble controls for the PC and the FD/DX latches
- operand bypass selects for the X-stage ALU inputs
- start/hold sequencing for the multi-cycle multiply/divide unit sitting beside the ALU in X.

Contains the multdiv FSM and a watchdog counter; the rest is decode logic gated by that state.

Parameters:
MD_TIMEOUT, 64, watchdog limit in cycles for one multdiv operation before a forced abort
REG_ZERO, 0, register index that is never written and never bypassed

Ports:
clock  input  1  master clock
reset  input  1  synchronous active-high reset
ir_d  input  32  instruction in FD latch
ir_x  input  32  instruction in DX latch
ir_m  input  32  instruction in XM latch
ir_w  input  32  instruction in MW latch
branch_taken  input  1  X stage resolved a taken branch/jump this cycle
md_ready  input  1  multdiv result valid (single-cycle pulse)
stall_pc  output  1  hold PC
stall_fd  output  1  hold FD latch
bubble_dx  output  1  load nop (32'b0) into DX instead of ir_d
flush_fd  output  1  load nop into FD
stall_xm  output  1  insert nop into XM (X occupied by running multdiv)
byp_a_sel  output  2  ALU A source: 0 regfile/DX, 1 XM O, 2 MW writeback data
byp_b_sel  output  2  ALU B / store-data source, same encoding
md_start  output  1  one-cycle pulse starting multdiv
md_result_sel  output  1  XM O takes multdiv result instead of ALU output
md_busy  output  1  FSM in RUN
md_timeout  output  1  sticky: a multdiv hit MD_TIMEOUT

Behaviour:
- Interface fixed: one clock `clock`; `reset` is synchronous, active-high, sampled on the rising edge.
- Fields: opcode [31:27], rd [26:22], rs [21:17], rt [16:12], aluop [6:2].
  - Writers: opcode 0 (R-type), 5 (addi), 8 (lw) write rd; opcode 3 (jal) writes r31.
  - Sources: rs for opcodes 0,2,5,6,7,8; rt for opcode 0; rd for opcodes 2,4,6,7.
- Bypass (combinational):
  - Per source, select 1 if the M-stage writer dest equals the source; else 2 if the W-stage writer dest equals it; else 0.
  - M has priority over W.
  - Dest == REG_ZERO never matches.
  - lw in M is never a bypass source; the load-use stall prevents that case.
- Load-use: ir_x opcode 8, dest != 0, dest matches any D source -> stall_pc=stall_fd=bubble_dx=1 for exactly one cycle.
- Flush: branch_taken=1 -> flush_fd=1 and bubble_dx=1 the same cycle; stall_pc=stall_fd=0. Flush overrides load-use.
- Multdiv FSM: states IDLE, RUN, DONE.
  - IDLE: ir_x opcode 0 with aluop 00110 (mul) or 00111 (div) -> md_start=1 for one cycle, cnt<=0, go RUN.
  - RUN: stall_pc=stall_fd=stall_xm=1, DX held, md_busy=1; cnt increments each cycle.
    - md_ready -> go DONE.
    - Else, when cnt==MD_TIMEOUT-1 -> set md_timeout, go DONE.
  - DONE: one cycle; md_result_sel=1, no stalls, X advances; -> IDLE. The same instruction is never restarted.
- Priority: RUN stalls dominate load-use. branch_taken cannot occur in RUN (X holds a mul/div); it is ignored if asserted.
- md_ready outside RUN is ignored.
- Reset: state IDLE, cnt 0, md_timeout 0. All outputs 0 during the reset cycle. Reset mid-RUN aborts the operation, and md_start does not re-pulse until a new mul/div reaches X.
- Latency: all stall/bypass outputs combinational from current IRs and state; md_start is a registered-state decode (asserts the cycle the mul/div first sits in X).

Optional Feature:
PIPE_PERF_CNT_EN:
- Defined: adds outputs stall_count[31:0], flush_count[31:0], md_count[31:0].
  - stall_count increments every cycle stall_pc=1.
  - flush_count increments every cycle flush_fd=1.
  - md_count increments on each md_start.
  - All counters saturate at 32'hFFFFFFFF; cleared by reset.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- ir_m=add r5 (opcode 0, rd 5), ir_w=addi r5, ir_x=add r1,r5,r5 -> byp_a_sel=byp_b_sel=1; remove ir_m writer -> both 2; rd=0 writer -> both 0.
- ir_x=lw r3, ir_d=add r4,r3,r2 -> stall_pc=stall_fd=bubble_dx=1 one cycle; next cycle with ir_x=0 -> all 0.
- ir_x=mul, md_ready pulsed 5 cycles later -> md_start 1 cycle, md_busy/stall_pc high 5 cycles, then md_result_sel=1 one cycle, then IDLE.
- ir_x=div, md_ready never -> after 64 RUN cycles md_timeout=1 (stays set), FSM DONE then IDLE.
- branch_taken=1 while load-use condition true -> flush_fd=bubble_dx=1, stall_pc=0.
- Reset asserted 3 cycles into RUN -> next cycle md_busy=0, md_timeout=0, all outputs 0; md_start pulses again when a new mul reaches X.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing: load-use stalls, branch flushes, X-stage bypass selects and multdiv start/hold.
// Build option PIPE_PERF_CNT_EN adds saturating stall/flush/multdiv event counters.
module pipeline_hazard_ctrl #(
  parameter int         MD_TIMEOUT = 64,
  parameter logic [4:0] REG_ZERO   = 5'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ir_d,
  input  logic [31:0] ir_x,
  input  logic [31:0] ir_m,
  input  logic [31:0] ir_w,
  input  logic        branch_taken,
  input  logic        md_ready,
  output logic        stall_pc,
  output logic        stall_fd,
  output logic        bubble_dx,
  output logic        flush_fd,
  output logic        stall_xm,
  output logic [1:0]  byp_a_sel,
  output logic [1:0]  byp_b_sel,
  output logic        md_start,
  output logic        md_result_sel,
  output logic        md_busy,
  output logic        md_timeout,
  output logic [1:0]  md_state_dbg
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count,
  output logic [31:0] md_count
`endif
);
  localparam int CW = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [4:0] OP_RTYPE = 5'd0;
  localparam logic [4:0] OP_JAL   = 5'd3;
  localparam logic [4:0] OP_ADDI  = 5'd5;
  localparam logic [4:0] OP_LW    = 5'd8;
  localparam logic [4:0] ALU_MUL  = 5'd6;
  localparam logic [4:0] ALU_DIV  = 5'd7;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} md_state_t;

  md_state_t     r_state;
  logic [CW-1:0] r_cnt;
  logic          r_md_timeout;

  // Register references are {valid, index}; a REG_ZERO destination is never valid.
  function automatic logic [5:0] f_dest(input logic [31:0] ir);
    logic [5:0] d;
    case (ir[31:27])
      OP_RTYPE, OP_ADDI, OP_LW: d = {1'b1, ir[26:22]};
      OP_JAL:                   d = {1'b1, 5'd31};
      default:                  d = 6'd0;
    endcase
    if (d[4:0] == REG_ZERO) d[5] = 1'b0;
    return d;
  endfunction

  function automatic logic [5:0] f_src_a(input logic [31:0] ir);
    case (ir[31:27])
      5'd0, 5'd2, 5'd5, 5'd6, 5'd7, 5'd8: f_src_a = {1'b1, ir[21:17]};
      default:                            f_src_a = 6'd0;
    endcase
  endfunction

  function automatic logic [5:0] f_src_b(input logic [31:0] ir);
    case (ir[31:27])
      5'd0:                   f_src_b = {1'b1, ir[16:12]};
      5'd2, 5'd4, 5'd6, 5'd7: f_src_b = {1'b1, ir[26:22]};
      default:                f_src_b = 6'd0;
    endcase
  endfunction

  function automatic logic [1:0] f_byp(input logic [5:0] src, input logic [5:0] m_dst,
                                       input logic m_is_lw, input logic [5:0] w_dst);
    if (src[5] && m_dst[5] && !m_is_lw && (m_dst[4:0] == src[4:0])) f_byp = 2'd1;
    else if (src[5] && w_dst[5] && (w_dst[4:0] == src[4:0]))          f_byp = 2'd2;
    else                                                              f_byp = 2'd0;
  endfunction

  logic [5:0] w_x_dest, w_m_dest, w_w_dest;
  logic [5:0] w_d_src_a, w_d_src_b, w_x_src_a, w_x_src_b;
  logic       w_m_is_lw, w_x_is_md, w_load_use;
  logic [1:0] w_byp_a, w_byp_b;
  logic       w_unused;

  assign w_x_dest  = f_dest(ir_x);
  assign w_m_dest  = f_dest(ir_m);
  assign w_w_dest  = f_dest(ir_w);
  assign w_d_src_a = f_src_a(ir_d);
  assign w_d_src_b = f_src_b(ir_d);
  assign w_x_src_a = f_src_a(ir_x);
  assign w_x_src_b = f_src_b(ir_x);
  assign w_m_is_lw = (ir_m[31:27] == OP_LW);
  assign w_x_is_md = (ir_x[31:27] == OP_RTYPE) && ((ir_x[6:2] == ALU_MUL) || (ir_x[6:2] == ALU_DIV));
  assign w_load_use = (ir_x[31:27] == OP_LW) && w_x_dest[5] &&
                      ((w_d_src_a[5] && (w_d_src_a[4:0] == w_x_dest[4:0])) ||
                       (w_d_src_b[5] && (w_d_src_b[4:0] == w_x_dest[4:0])));
  assign w_byp_a  = f_byp(w_x_src_a, w_m_dest, w_m_is_lw, w_w_dest);
  assign w_byp_b  = f_byp(w_x_src_b, w_m_dest, w_m_is_lw, w_w_dest);
  assign w_unused = ^{ir_d[11:0], ir_x[11:7], ir_x[1:0], ir_m[21:0], ir_w[21:0]};
  assign md_state_dbg = r_state;

  // Handshake: md_start is a one-cycle pulse when a mul/div first sits in X while IDLE;
  // md_ready is a one-cycle result pulse honoured only in RUN. Neither side can back-pressure.
  always_comb begin
    stall_pc      = 1'b0;
    stall_fd      = 1'b0;
    bubble_dx     = 1'b0;
    flush_fd      = 1'b0;
    stall_xm      = 1'b0;
    byp_a_sel     = 2'd0;
    byp_b_sel     = 2'd0;
    md_start      = 1'b0;
    md_result_sel = 1'b0;
    md_busy       = 1'b0;
    md_timeout    = 1'b0;
    if (!reset) begin
      byp_a_sel  = w_byp_a;
      byp_b_sel  = w_byp_b;
      md_timeout = r_md_timeout;
      case (r_state)
        S_RUN: begin
          stall_pc = 1'b1;
          stall_fd = 1'b1;
          stall_xm = 1'b1;
          md_busy  = 1'b1;
        end
        default: begin
          md_start      = (r_state == S_IDLE) && w_x_is_md;
          md_result_sel = (r_state == S_DONE);
          if (branch_taken) begin
            flush_fd  = 1'b1;
            bubble_dx = 1'b1;
          end else if (w_load_use) begin
            stall_pc  = 1'b1;
            stall_fd  = 1'b1;
            bubble_dx = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_md_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_x_is_md) begin
          r_state <= S_RUN;
          r_cnt   <= '0;
        end
        S_RUN: begin
          r_cnt <= r_cnt + CW'(1);
          if (md_ready) begin
            r_state <= S_DONE;
          end else if (r_cnt == CW'(MD_TIMEOUT - 1)) begin
            r_md_timeout <= 1'b1;
            r_state      <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] r_stall_count, r_flush_count, r_md_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
      r_md_count    <= '0;
    end else begin
      if (stall_pc && !(&r_stall_count)) r_stall_count <= r_stall_count + 32'd1;
      if (flush_fd && !(&r_flush_count)) r_flush_count <= r_flush_count + 32'd1;
      if (md_start && !(&r_md_count))    r_md_count    <= r_md_count + 32'd1;
    end
  end

  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;
  assign md_count    = r_md_count;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboarded bench for pipeline_hazard_ctrl: directed hazard scenarios plus randomized traffic
// checked against a register-number reference model.
module tb_pipeline_hazard_ctrl;
  localparam int MD_TIMEOUT = 64;
  localparam int W = 13;
  localparam logic [31:0] NOP = 32'd0;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] ir_d, ir_x, ir_m, ir_w;
  logic        branch_taken, md_ready;
  logic        stall_pc, stall_fd, bubble_dx, flush_fd, stall_xm;
  logic [1:0]  byp_a_sel, byp_b_sel;
  logic        md_start, md_result_sel, md_busy, md_timeout;
  logic [1:0]  md_state_dbg_unused;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_count, flush_count, md_count;
`endif

  pipeline_hazard_ctrl #(.MD_TIMEOUT(MD_TIMEOUT), .REG_ZERO(5'd0)) dut (
    .clock(clock), .reset(reset),
    .ir_d(ir_d), .ir_x(ir_x), .ir_m(ir_m), .ir_w(ir_w),
    .branch_taken(branch_taken), .md_ready(md_ready),
    .stall_pc(stall_pc), .stall_fd(stall_fd), .bubble_dx(bubble_dx),
    .flush_fd(flush_fd), .stall_xm(stall_xm),
    .byp_a_sel(byp_a_sel), .byp_b_sel(byp_b_sel),
    .md_start(md_start), .md_result_sel(md_result_sel),
    .md_busy(md_busy), .md_timeout(md_timeout),
    .md_state_dbg(md_state_dbg_unused)
`ifdef PIPE_PERF_CNT_EN
    , .stall_count(stall_count), .flush_count(flush_count), .md_count(md_count)
`endif
  );

  // clock/reset block
  always #5 clock = ~clock;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  // reference model state: multdiv progress as plain counters/flags
  bit m_active = 0;
  bit m_done   = 0;
  bit m_to     = 0;
  int m_run    = 0;
  int m_stalls = 0;
  int m_flushes = 0;
  int m_starts = 0;

  function automatic logic [31:0] mk(input int op, input int rd, input int rs, input int rt, input int alu);
    logic [31:0] r;
    r = '0;
    r[31:27] = op[4:0];
    r[26:22] = rd[4:0];
    r[21:17] = rs[4:0];
    r[16:12] = rt[4:0];
    r[6:2]   = alu[4:0];
    return r;
  endfunction

  function automatic int dest_of(input logic [31:0] ir);
    int op, d;
    op = int'(ir[31:27]);
    if (op == 0 || op == 5 || op == 8) d = int'(ir[26:22]);
    else if (op == 3)                  d = 31;
    else                               d = -1;
    if (d == 0) d = -1;
    return d;
  endfunction

  function automatic int src_a(input logic [31:0] ir);
    int op;
    op = int'(ir[31:27]);
    if (op == 0 || op == 2 || op == 5 || op == 6 || op == 7 || op == 8) return int'(ir[21:17]);
    return -1;
  endfunction

  function automatic int src_b(input logic [31:0] ir);
    int op;
    op = int'(ir[31:27]);
    if (op == 0) return int'(ir[16:12]);
    if (op == 2 || op == 4 || op == 6 || op == 7) return int'(ir[26:22]);
    return -1;
  endfunction

  function automatic logic [1:0] byp_of(input int src, input logic [31:0] m, input logic [31:0] w);
    if (src < 0) return 2'd0;
    if (m[31:27] != 5'd8 && dest_of(m) == src) return 2'd1;
    if (dest_of(w) == src) return 2'd2;
    return 2'd0;
  endfunction

  function automatic bit is_md(input logic [31:0] ir);
    return (ir[31:27] == 5'd0) && (ir[6:2] == 5'd6 || ir[6:2] == 5'd7);
  endfunction

  function automatic logic [31:0] rand_ir();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 10))
      0, 1:    r[31:27] = 5'd0;
      2:       r[31:27] = 5'd2;
      3:       r[31:27] = 5'd3;
      4:       r[31:27] = 5'd4;
      5:       r[31:27] = 5'd5;
      6:       r[31:27] = 5'd6;
      7:       r[31:27] = 5'd7;
      8, 9:    r[31:27] = 5'd8;
      default: r[31:27] = 5'd1;
    endcase
    r[26:22] = 5'($urandom_range(0, 7));
    r[21:17] = 5'($urandom_range(0, 7));
    r[16:12] = 5'($urandom_range(0, 7));
    r[6:2]   = 5'($urandom_range(0, 7));
    return r;
  endfunction

  // driver: applies one cycle of inputs, pushes the model's expected outputs, advances the model
  task automatic drive(input logic [31:0] d, input logic [31:0] x, input logic [31:0] m,
                       input logic [31:0] w, input logic br, input logic rdy, input logic rst,
                       input string tag);
    logic       spc, sfd, bdx, ffd, sxm, mst, mrs, mbz, mto;
    logic [1:0] ba, bb;
    int         xd;
    @(posedge clock);
    #1;
    ir_d = d; ir_x = x; ir_m = m; ir_w = w;
    branch_taken = br; md_ready = rdy; reset = rst;
    {spc, sfd, bdx, ffd, sxm, mst, mrs, mbz, mto} = '0;
    ba = 2'd0;
    bb = 2'd0;
    if (!rst) begin
      ba  = byp_of(src_a(x), m, w);
      bb  = byp_of(src_b(x), m, w);
      mto = m_to;
      if (m_active) begin
        spc = 1'b1; sfd = 1'b1; sxm = 1'b1; mbz = 1'b1;
      end else begin
        mst = !m_done && is_md(x);
        mrs = m_done;
        xd  = dest_of(x);
        if (br) begin
          ffd = 1'b1; bdx = 1'b1;
        end else if (x[31:27] == 5'd8 && xd >= 0 && (xd == src_a(d) || xd == src_b(d))) begin
          spc = 1'b1; sfd = 1'b1; bdx = 1'b1;
        end
      end
    end
    exp_q.push_back({spc, sfd, bdx, ffd, sxm, ba, bb, mst, mrs, mbz, mto});
    tag_q.push_back(tag);
    if (rst) begin
      m_active = 0; m_done = 0; m_to = 0; m_run = 0;
      m_stalls = 0; m_flushes = 0; m_starts = 0;
    end else begin
      m_stalls  += int'(spc);
      m_flushes += int'(ffd);
      m_starts  += int'(mst);
      if (m_active) begin
        if (rdy) begin
          m_active = 0; m_done = 1;
        end else if (m_run + 1 == MD_TIMEOUT) begin
          m_active = 0; m_done = 1; m_to = 1;
        end
        m_run++;
      end else if (m_done) begin
        m_done = 0;
      end else if (is_md(x)) begin
        m_active = 1; m_run = 0;
      end
    end
  endtask

  // monitor: every cycle the controller presents a full output set; compare mid-cycle
  initial begin
    logic [W-1:0] e, got;
    string        t;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        got = {stall_pc, stall_fd, bubble_dx, flush_fd, stall_xm, byp_a_sel, byp_b_sel,
               md_start, md_result_sel, md_busy, md_timeout};
        n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL %s: got %b expected %b", t, got, e);
        end
      end
    end
  end

  initial begin
    logic [31:0] mul_i, div_i, lw_r3, use_r3;
    mul_i  = mk(0, 6, 1, 2, 6);
    div_i  = mk(0, 7, 3, 4, 7);
    lw_r3  = mk(8, 3, 1, 0, 0);
    use_r3 = mk(0, 4, 3, 2, 0);
    reset = 1'b1; ir_d = NOP; ir_x = NOP; ir_m = NOP; ir_w = NOP;
    branch_taken = 1'b0; md_ready = 1'b0;

    drive(NOP, mul_i, NOP, NOP, 1'b1, 1'b0, 1'b1, "reset_outputs");
    drive(NOP, NOP, NOP, NOP, 1'b0, 1'b0, 1'b1, "reset_hold");
    drive(NOP, NOP, NOP, NOP, 1'b0, 1'b0, 1'b0, "idle_after_reset");

    // bypass priority and REG_ZERO
    drive(NOP, mk(0, 1, 5, 5, 0), mk(0, 5, 0, 0, 0), mk(5, 5, 0, 0, 0), 1'b0, 1'b0, 1'b0, "byp_m_priority");
    drive(NOP, mk(0, 1, 5, 5, 0), NOP, mk(5, 5, 0, 0, 0), 1'b0, 1'b0, 1'b0, "byp_w_only");
    drive(NOP, mk(0, 1, 0, 0, 0), mk(0, 0, 0, 0, 0), mk(5, 0, 0, 0, 0), 1'b0, 1'b0, 1'b0, "byp_reg_zero");
    drive(NOP, mk(0, 1, 5, 5, 0), mk(8, 5, 0, 0, 0), mk(5, 5, 0, 0, 0), 1'b0, 1'b0, 1'b0, "byp_lw_in_m");
    drive(NOP, mk(7, 31, 2, 0, 0), mk(3, 9, 0, 0, 0), NOP, 1'b0, 1'b0, 1'b0, "byp_jal_r31");

    // load-use then clear
    drive(use_r3, lw_r3, NOP, NOP, 1'b0, 1'b0, 1'b0, "load_use_stall");
    drive(use_r3, NOP, NOP, NOP, 1'b0, 1'b0, 1'b0, "load_use_clear");
    drive(mk(0, 4, 1, 2, 0), lw_r3, NOP, NOP, 1'b0, 1'b0, 1'b0, "load_no_dep");

    // mul with md_ready five cycles after start
    drive(NOP, mul_i, NOP, NOP, 1'b0, 1'b0, 1'b0, "mul_start");
    for (int i = 1; i <= 5; i++) drive(NOP, mul_i, NOP, NOP, 1'b0, (i == 5), 1'b0, "mul_run");
    drive(NOP, mul_i, NOP, NOP, 1'b0, 1'b0, 1'b0, "mul_done");
    drive(NOP, NOP, NOP, NOP, 1'b0, 1'b0, 1'b0, "mul_idle");

    // div that never completes
    drive(NOP, div_i, NOP, NOP, 1'b0, 1'b0, 1'b0, "div_start");
    for (int i = 0; i < MD_TIMEOUT; i++) drive(NOP, div_i, NOP, NOP, 1'b0, 1'b0, 1'b0, "div_run");
    drive(NOP, div_i, NOP, NOP, 1'b0, 1'b0, 1'b0, "div_timeout_done");
    for (int i = 0; i < 3; i++) drive(NOP, NOP, NOP, NOP, 1'b0, 1'b0, 1'b0, "timeout_sticky");

    // flush overrides load-use
    drive(use_r3, lw_r3, NOP, NOP, 1'b1, 1'b0, 1'b0, "flush_over_load_use");
    drive(NOP, NOP, NOP, NOP, 1'b0, 1'b1, 1'b0, "md_ready_idle_ignored");

    // reset three cycles into RUN
    drive(NOP, mul_i, NOP, NOP, 1'b0, 1'b0, 1'b0, "rst_mul_start");
    for (int i = 0; i < 3; i++) drive(NOP, mul_i, NOP, NOP, 1'b1, 1'b0, 1'b0, "rst_mul_run");
    drive(NOP, NOP, NOP, NOP, 1'b0, 1'b0, 1'b1, "rst_mid_run");
    drive(NOP, NOP, NOP, NOP, 1'b0, 1'b0, 1'b0, "post_rst_quiet");
    drive(NOP, mul_i, NOP, NOP, 1'b0, 1'b0, 1'b0, "restart_mul");
    drive(NOP, mul_i, NOP, NOP, 1'b0, 1'b1, 1'b0, "restart_run");
    drive(NOP, mul_i, NOP, NOP, 1'b0, 1'b0, 1'b0, "restart_done");

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive(rand_ir(), rand_ir(), rand_ir(), rand_ir(), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 79) == 0), "random");
    end
    drive(NOP, NOP, NOP, NOP, 1'b0, 1'b0, 1'b0, "final_idle");

    @(negedge clock);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
`ifdef PIPE_PERF_CNT_EN
    n_checks++;
    if (stall_count !== 32'(m_stalls)) begin
      n_fail++;
      $display("FAIL stall_count: got %0d expected %0d", stall_count, m_stalls);
    end
    n_checks++;
    if (flush_count !== 32'(m_flushes)) begin
      n_fail++;
      $display("FAIL flush_count: got %0d expected %0d", flush_count, m_flushes);
    end
    n_checks++;
    if (md_count !== 32'(m_starts)) begin
      n_fail++;
      $display("FAIL md_count: got %0d expected %0d", md_count, m_starts);
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
